// File: rtl/rcpu_mem_pkg.sv
// Shared encodings for the RCPU memory access unit.
// Mode, state and stack-page constants used by the core and the unit.
package rcpu_mem_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_PAGED  = 2'b01;
    localparam logic [1:0] MODE_STACK  = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Legacy datapath names, kept as aliases of the request modes.
    localparam logic [1:0] READ_FROM_DIRECT = MODE_DIRECT;
    localparam logic [1:0] READ_FROM_PAGE   = MODE_PAGED;
    localparam logic [1:0] READ_FROM_STACK  = MODE_STACK;

    localparam logic [15:0] DEFAULT_STACK_PAGE = 16'hD000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_FIN
    } state_e;

endpackage

// File: rtl/rcpu_mem_timeout.sv
// Per-beat wait-state counter; expired marks the TIMEOUT-th wait cycle.
module rcpu_mem_timeout #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/rcpu_mem_unit.sv
// RCPU memory access unit: turns one core request into one or two
// bus beats with wait states, timeout and assembled read data.
module rcpu_mem_unit
    import rcpu_mem_pkg::*;
#(
    parameter int          M          = 16,
    parameter int          N          = 32,
    parameter logic [M-1:0] STACK_PAGE = M'(DEFAULT_STACK_PAGE),
    parameter int          TIMEOUT    = 255,
    parameter int          TW         = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic           reqWrite,
    input  logic           reqDouble,
    input  logic [1:0]     reqMode,
    input  logic [M-1:0]   reqAddrHi,
    input  logic [M-1:0]   reqAddrLo,
    input  logic [2*M-1:0] reqData,
    input  logic [M-1:0]   page,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2*M-1:0] rdata,
    output logic [N-1:0]   memAddr,
    output logic [M-1:0]   memWrite,
    input  logic [M-1:0]   memRData,
    output logic           memRE,
    output logic           memWE,
    input  logic           memReady,
    output logic           stall
);

    state_e         state_q, state_d;
    logic           write_q, write_d;
    logic           double_q, double_d;
    logic           direct_q, direct_d;
    logic [2*M-1:0] wdata_q, wdata_d;
    logic [N-1:0]   addr_q, addr_d;
    logic [M-1:0]   wr_q, wr_d;
    logic           re_q, re_d;
    logic           we_q, we_d;
    logic [M-1:0]   stage_q, stage_d;
    logic [2*M-1:0] rdata_q, rdata_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           tmo_clr;
    logic           tmo_inc;
    logic           tmo_exp;
    logic [N-1:0]   base_addr;
    logic [N-1:0]   next_addr;

    rcpu_mem_timeout #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .inc     (tmo_inc),
        .expired (tmo_exp)
    );

    assign base_addr = (reqMode == MODE_PAGED) ? {page, reqAddrLo} :
                       (reqMode == MODE_STACK) ? {STACK_PAGE, reqAddrLo} :
                                                 {reqAddrHi, reqAddrLo};

    // Paged and stack transfers never leave their page.
    assign next_addr = direct_q ? addr_q + N'(1)
                                : {addr_q[N-1:M], addr_q[M-1:0] + M'(1)};

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        double_d = double_q;
        direct_d = direct_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        re_d     = re_q;
        we_d     = we_q;
        stage_d  = stage_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tmo_clr  = 1'b1;
        tmo_inc  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (reqMode == MODE_RSVD) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = ST_BEAT0;
                        write_d  = reqWrite;
                        double_d = reqDouble;
                        direct_d = (reqMode == MODE_DIRECT);
                        wdata_d  = reqData;
                        addr_d   = base_addr;
                        wr_d     = reqData[M-1:0];
                        re_d     = !reqWrite;
                        we_d     = reqWrite;
                    end
                end
            end
            ST_BEAT0, ST_BEAT1: begin
                if (memReady) begin
                    if (state_q == ST_BEAT0 && double_q) begin
                        state_d = ST_BEAT1;
                        stage_d = memRData;
                        addr_d  = next_addr;
                        wr_d    = wdata_q[2*M-1:M];
                    end else begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        re_d    = 1'b0;
                        we_d    = 1'b0;
                        if (!write_q) begin
                            rdata_d = double_q ? {memRData, stage_q}
                                               : {{M{1'b0}}, memRData};
                        end
                    end
                end else if (tmo_exp) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    tmo_clr = 1'b0;
                    tmo_inc = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            double_q <= 1'b0;
            direct_q <= 1'b0;
            wdata_q  <= '0;
            addr_q   <= '0;
            wr_q     <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            stage_q  <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            double_q <= double_d;
            direct_q <= direct_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            re_q     <= re_d;
            we_q     <= we_d;
            stage_q  <= stage_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign memAddr  = addr_q;
    assign memWrite = wr_q;
    assign memRE    = re_q;
    assign memWE    = we_q;
    assign stall    = (state_q == ST_BEAT0 || state_q == ST_BEAT1) && !memReady;

endmodule

// File: tb/tb_rcpu_mem_unit.sv
// Self-checking bench for rcpu_mem_unit: bus slave with wait states,
// memory model and per-scenario tasks.
module tb_rcpu_mem_unit;
    import rcpu_mem_pkg::*;

    localparam int M   = 16;
    localparam int N   = 32;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        reqWrite;
    logic        reqDouble;
    logic [1:0]  reqMode;
    logic [15:0] reqAddrHi;
    logic [15:0] reqAddrLo;
    logic [31:0] reqData;
    logic [15:0] page;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] memAddr;
    logic [15:0] memWrite;
    logic [15:0] memRData = 16'h0;
    logic        memRE;
    logic        memWE;
    logic        memReady = 1'b0;
    logic        stall;

    rcpu_mem_unit #(
        .M(M), .N(N), .STACK_PAGE(16'hD000), .TIMEOUT(TMO), .TW(8)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .reqWrite(reqWrite),
        .reqDouble(reqDouble), .reqMode(reqMode), .reqAddrHi(reqAddrHi),
        .reqAddrLo(reqAddrLo), .reqData(reqData), .page(page),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .memAddr(memAddr), .memWrite(memWrite), .memRData(memRData),
        .memRE(memRE), .memWE(memWE), .memReady(memReady), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic        re;
        logic [15:0] wd;
    } beat_t;

    int n_chk = 0;
    int n_fail = 0;

    // bus slave state
    logic [15:0] mem [logic [31:0]];
    logic [15:0] pre [logic [31:0]];
    beat_t       blog[$];
    int          wq[$];
    int          bstart = 0;
    int          cur = 0;
    bit          in_beat = 0;
    bit          hang = 0;

    // transaction observations
    int          obs_lat, obs_en, obs_stalls, obs_chg, obs_dcnt;
    logic        obs_err;
    logic [31:0] obs_rdata;
    beat_t       obs_beats[$];
    logic [31:0] exp_rdata;

    function automatic logic [15:0] mem_rd(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        if (pre.exists(a)) return pre[a];
        return a[15:0] ^ a[31:16] ^ 16'h5A5A;
    endfunction

    function automatic logic [31:0] m_base(logic [1:0] md, logic [15:0] hi,
                                           logic [15:0] lo, logic [15:0] pg);
        case (md)
            2'b01:   return {pg, lo};
            2'b10:   return {16'hD000, lo};
            default: return {hi, lo};
        endcase
    endfunction

    function automatic logic [31:0] m_next(logic [1:0] md, logic [31:0] a);
        if (md == 2'b00) return a + 32'd1;
        return {a[31:16], a[15:0] + 16'd1};
    endfunction

    always @(negedge clk) begin
        if (memRE || memWE) begin
            if (!in_beat) begin
                in_beat = 1;
                if (hang) begin
                    cur = 1000000;
                end else begin
                    cur = (bstart < wq.size()) ? wq[bstart] : 0;
                    bstart++;
                end
            end
            if (cur > 0) begin
                memReady = 1'b0;
                memRData = 16'($urandom);
                cur--;
            end else begin
                memReady = 1'b1;
                memRData = mem_rd(memAddr);
                if (memWE) mem[memAddr] = memWrite;
                blog.push_back('{memAddr, memWE, memRE, memWrite});
                in_beat = 0;
            end
        end else begin
            memReady = 1'b0;
            in_beat = 0;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic run_txn(input logic w, input logic d, input logic [1:0] md,
                           input logic [15:0] hi, input logic [15:0] lo,
                           input logic [15:0] pg, input logic [31:0] data);
        int          lidx;
        logic        pst;
        logic [31:0] pa;
        logic [15:0] pw;
        lidx = blog.size();
        req = 1; reqWrite = w; reqDouble = d; reqMode = md;
        reqAddrHi = hi; reqAddrLo = lo; page = pg; reqData = data;
        cyc();
        req = 0;
        reqAddrHi = 16'($urandom); reqAddrLo = 16'($urandom);
        page = 16'($urandom); reqData = $urandom;
        reqMode = 2'($urandom); reqWrite = 1'($urandom); reqDouble = 1'($urandom);
        obs_lat = -1; obs_en = 0; obs_stalls = 0; obs_chg = 0; obs_dcnt = 0;
        obs_err = 1'b0; obs_rdata = '0;
        pst = 0; pa = '0; pw = '0;
        for (int k = 1; k <= 60; k++) begin
            if (memRE || memWE) begin
                obs_en++;
                if (pst && (memAddr !== pa || (memWE && memWrite !== pw))) obs_chg++;
            end
            if (stall) obs_stalls++;
            pst = stall; pa = memAddr; pw = memWrite;
            if (done) begin
                obs_lat = k; obs_err = err; obs_rdata = rdata; obs_dcnt++;
                cyc();
                if (done) obs_dcnt++;
                break;
            end
            cyc();
        end
        obs_beats.delete();
        for (int i = lidx; i < blog.size(); i++) obs_beats.push_back(blog[i]);
    endtask

    task automatic test_reset();
        n_chk++;
        if ({busy, done, err, memRE, memWE, stall} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, done, err, memRE, memWE, stall});
        end
        n_chk++;
        if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata);
        end
        n_chk++;
        if (memAddr !== 32'h0 || memWrite !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h/%h want 0/0", memAddr, memWrite);
        end
        exp_rdata = 32'h0;
    endtask

    task automatic test_single_read();
        pre[32'h0012_3400] = 16'hBEEF;
        wq.push_back(0);
        run_txn(1'b0, 1'b0, MODE_PAGED, 16'h7777, 16'h3400, 16'h0012, 32'h0);
        exp_rdata = 32'h0000_BEEF;
        n_chk++;
        if (obs_lat != 2 || obs_err !== 1'b0 || obs_dcnt != 1) begin
            n_fail++;
            $display("FAIL sread_timing: got lat %0d err %b pulses %0d want 2 0 1",
                     obs_lat, obs_err, obs_dcnt);
        end
        n_chk++;
        if (obs_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL sread_rdata: got %h want %h", obs_rdata, exp_rdata);
        end
        n_chk++;
        if (obs_beats.size() != 1 || obs_en != 1 ||
            obs_beats[0].a !== 32'h0012_3400 || obs_beats[0].re !== 1'b1) begin
            n_fail++;
            $display("FAIL sread_bus: got %0d beats %0d en cycles want 1 beat re @00123400",
                     obs_beats.size(), obs_en);
        end
    endtask

    task automatic test_double_write();
        wq.push_back(0); wq.push_back(0);
        run_txn(1'b1, 1'b1, MODE_DIRECT, 16'h0001, 16'hFFFF, 16'h0, 32'hCAFE_1234);
        n_chk++;
        if (obs_lat != 3 || obs_err !== 1'b0 || obs_dcnt != 1) begin
            n_fail++;
            $display("FAIL dwrite_timing: got lat %0d err %b pulses %0d want 3 0 1",
                     obs_lat, obs_err, obs_dcnt);
        end
        n_chk++;
        if (obs_beats.size() != 2) begin
            n_fail++; $display("FAIL dwrite_beats: got %0d want 2", obs_beats.size());
        end else if (obs_beats[0].a !== 32'h0001_FFFF || obs_beats[0].wd !== 16'h1234 ||
                     obs_beats[1].a !== 32'h0002_0000 || obs_beats[1].wd !== 16'hCAFE ||
                     obs_beats[0].we !== 1'b1 || obs_beats[1].we !== 1'b1 ||
                     obs_beats[0].re !== 1'b0 || obs_beats[1].re !== 1'b0) begin
            n_fail++;
            $display("FAIL dwrite_beats: got %h:%h %h:%h want 0001ffff:1234 00020000:cafe",
                     obs_beats[0].a, obs_beats[0].wd, obs_beats[1].a, obs_beats[1].wd);
        end
        n_chk++;
        if (rdata !== exp_rdata) begin
            n_fail++; $display("FAIL dwrite_rdata: got %h want %h", rdata, exp_rdata);
        end
    endtask

    task automatic test_reserved();
        run_txn(1'b0, 1'b1, MODE_RSVD, 16'h1111, 16'h2222, 16'h3333, 32'h0);
        n_chk++;
        if (obs_lat < 1 || obs_lat > 2 || obs_err !== 1'b1 || obs_dcnt != 1) begin
            n_fail++;
            $display("FAIL rsvd_done: got lat %0d err %b pulses %0d want 1..2 1 1",
                     obs_lat, obs_err, obs_dcnt);
        end
        n_chk++;
        if (obs_en != 0 || obs_beats.size() != 0) begin
            n_fail++;
            $display("FAIL rsvd_bus: got %0d enable cycles want 0", obs_en);
        end
        n_chk++;
        if (obs_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL rsvd_rdata: got %h want %h", obs_rdata, exp_rdata);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] v;
        hang = 1;
        run_txn(1'b0, 1'b0, MODE_PAGED, 16'h0, 16'h0100, 16'h0042, 32'h0);
        hang = 0;
        n_chk++;
        if (obs_lat != TMO + 1 || obs_err !== 1'b1 || obs_dcnt != 1) begin
            n_fail++;
            $display("FAIL tmo_done: got lat %0d err %b pulses %0d want %0d 1 1",
                     obs_lat, obs_err, obs_dcnt, TMO + 1);
        end
        n_chk++;
        if (obs_stalls != TMO || obs_beats.size() != 0) begin
            n_fail++;
            $display("FAIL tmo_stall: got %0d stalls %0d beats want %0d 0",
                     obs_stalls, obs_beats.size(), TMO);
        end
        n_chk++;
        if (obs_rdata !== 32'h0000_BEEF) begin
            n_fail++; $display("FAIL tmo_rdata: got %h want 0000beef", obs_rdata);
        end
        v = mem_rd(32'h0ABC_0010);
        wq.push_back(0);
        run_txn(1'b0, 1'b0, MODE_DIRECT, 16'h0ABC, 16'h0010, 16'h0, 32'h0);
        exp_rdata = {16'h0, v};
        n_chk++;
        if (obs_lat != 2 || obs_err !== 1'b0 || obs_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL tmo_next: got lat %0d err %b rdata %h want 2 0 %h",
                     obs_lat, obs_err, obs_rdata, exp_rdata);
        end
    endtask

    task automatic test_stack_wait();
        logic [15:0] v0, v1;
        v0 = mem_rd(32'hD000_FFFF);
        v1 = mem_rd(32'hD000_0000);
        wq.push_back(3); wq.push_back(0);
        run_txn(1'b0, 1'b1, MODE_STACK, 16'h1234, 16'hFFFF, 16'h5678, 32'h0);
        exp_rdata = {v1, v0};
        n_chk++;
        if (obs_stalls != 3 || obs_chg != 0 || obs_lat != 6) begin
            n_fail++;
            $display("FAIL stack_wait: got stalls %0d changes %0d lat %0d want 3 0 6",
                     obs_stalls, obs_chg, obs_lat);
        end
        n_chk++;
        if (obs_beats.size() != 2) begin
            n_fail++; $display("FAIL stack_addr: got %0d beats want 2", obs_beats.size());
        end else if (obs_beats[0].a !== 32'hD000_FFFF || obs_beats[1].a !== 32'hD000_0000) begin
            n_fail++;
            $display("FAIL stack_addr: got %h %h want d000ffff d0000000",
                     obs_beats[0].a, obs_beats[1].a);
        end
        n_chk++;
        if (obs_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL stack_rdata: got %h want %h", obs_rdata, exp_rdata);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            logic        w, d;
            logic [1:0]  md;
            logic [15:0] hi, lo, pg, v0, v1;
            logic [31:0] data, a0, a1;
            int          w0, w1, nb, lat;
            w = 1'($urandom); d = 1'($urandom);
            md = 2'($urandom_range(0, 2));
            hi = 16'($urandom); lo = 16'($urandom); pg = 16'($urandom);
            data = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                lo = 16'hFFFF;
                if ($urandom_range(0, 1) == 0) hi = 16'hFFFF;
            end
            w0 = $urandom_range(0, 3); w1 = $urandom_range(0, 3);
            a0 = m_base(md, hi, lo, pg);
            a1 = m_next(md, a0);
            v0 = mem_rd(a0); v1 = mem_rd(a1);
            wq.push_back(w0);
            if (d) wq.push_back(w1);
            nb = d ? 2 : 1;
            lat = (w0 + 1) + (d ? w1 + 1 : 0) + 1;
            run_txn(w, d, md, hi, lo, pg, data);
            if (!w) exp_rdata = d ? {v1, v0} : {16'h0, v0};
            n_chk++;
            if (obs_lat != lat || obs_err !== 1'b0 || obs_dcnt != 1 ||
                obs_stalls != w0 + (d ? w1 : 0) || obs_chg != 0) begin
                n_fail++;
                $display("FAIL rand%0d_timing: got lat %0d err %b pulses %0d stalls %0d chg %0d want lat %0d err 0 pulses 1",
                         it, obs_lat, obs_err, obs_dcnt, obs_stalls, obs_chg, lat);
            end
            n_chk++;
            if (obs_rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL rand%0d_rdata: got %h want %h", it, obs_rdata, exp_rdata);
            end
            n_chk++;
            if (obs_beats.size() != nb) begin
                n_fail++;
                $display("FAIL rand%0d_beats: got %0d want %0d", it, obs_beats.size(), nb);
            end else begin
                for (int b = 0; b < nb; b++) begin
                    logic [31:0] ea;
                    logic [15:0] ed;
                    ea = (b == 0) ? a0 : a1;
                    ed = (b == 0) ? data[15:0] : data[31:16];
                    if (obs_beats[b].a !== ea || obs_beats[b].we !== w ||
                        obs_beats[b].re !== !w || (w && obs_beats[b].wd !== ed)) begin
                        n_fail++;
                        $display("FAIL rand%0d_beat%0d: got %h we%b wd %h want %h we%b wd %h",
                                 it, b, obs_beats[b].a, obs_beats[b].we, obs_beats[b].wd,
                                 ea, w, ed);
                        break;
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  mask;
        logic        b3;
        logic [15:0] v;
        int          lidx;
        v = mem_rd(32'h0033_0044);
        wq.push_back(0); wq.push_back(0);
        lidx = blog.size();
        req = 1; reqWrite = 0; reqDouble = 0; reqMode = MODE_DIRECT;
        reqAddrHi = 16'h0033; reqAddrLo = 16'h0044;
        mask = '0; b3 = 1'b1;
        cyc();
        for (int k = 1; k <= 7; k++) begin
            if (done) mask[k] = 1'b1;
            if (k == 3) b3 = busy;
            if (k == 5) req = 0;
            cyc();
        end
        exp_rdata = {16'h0, v};
        n_chk++;
        if (mask !== 8'b0010_0100 || b3 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pulses: got done mask %b idle-busy %b want 00100100 0", mask, b3);
        end
        n_chk++;
        if (blog.size() - lidx != 2 || rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL b2b_result: got %0d beats rdata %h want 2 %h",
                     blog.size() - lidx, rdata, exp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        logic [15:0] v;
        wq.push_back(0); wq.push_back(3);
        req = 1; reqWrite = 0; reqDouble = 1; reqMode = MODE_DIRECT;
        reqAddrHi = 16'h0100; reqAddrLo = 16'h0200;
        cyc();
        req = 0;
        cyc();
        n_chk++;
        if (memRE !== 1'b1 || memAddr !== 32'h0100_0201) begin
            n_fail++;
            $display("FAIL rmid_beat1: got re %b addr %h want 1 01000201", memRE, memAddr);
        end
        rst = 0;
        cyc();
        rst = 1;
        exp_rdata = 32'h0;
        n_chk++;
        if (busy !== 1'b0 || memRE !== 1'b0 || memWE !== 1'b0 ||
            done !== 1'b0 || rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL rmid_state: got busy %b re %b we %b done %b rdata %h want 0 0 0 0 0",
                     busy, memRE, memWE, done, rdata);
        end
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (done || memRE || memWE) seen = 1;
            cyc();
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL rmid_quiet: got activity %b want 0", seen);
        end
        v = mem_rd(32'h0009_0009);
        wq.push_back(1);
        run_txn(1'b0, 1'b0, MODE_DIRECT, 16'h0009, 16'h0009, 16'h0, 32'h0);
        exp_rdata = {16'h0, v};
        n_chk++;
        if (obs_lat != 3 || obs_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL rmid_recover: got lat %0d rdata %h want 3 %h",
                     obs_lat, obs_rdata, exp_rdata);
        end
    endtask

    initial begin
        rst = 0; req = 0; reqWrite = 0; reqDouble = 0; reqMode = 2'b00;
        reqAddrHi = '0; reqAddrLo = '0; reqData = '0; page = '0;
        exp_rdata = '0;
        cyc(); cyc(); cyc();
        test_reset();
        rst = 1;
        cyc();
        test_single_read();
        test_double_write();
        test_reserved();
        test_timeout();
        test_stack_wait();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
